mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_port_arbiter_if.sv | 18 +
 rtl/arb_timeout_counter.sv | 30 +++
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-master memory port arbiter: grant state encoding
// and master index constants.
package titan_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  localparam logic MST_I = 1'b0;
  localparam logic MST_D = 1'b1;

  localparam int unsigned WB_AW = 32;
  localparam int unsigned WB_DW = 32;
  localparam int unsigned WB_SW = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Wishbone classic bus bundle. Handshake: a beat is requested while cyc and stb
// are both high; the slave completes it with a one-cycle ack or err.
interface mem_port_arbiter_if;

  logic [31:0] addr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic [3:0]  sel;
  logic        cyc;
  logic        stb;
  logic        we;
  logic        ack;
  logic        err;

  modport master (output addr, wdat, sel, cyc, stb, we, input  rdat, ack, err);
  modport slave  (input  addr, wdat, sel, cyc, stb, we, output rdat, ack, err);

endinterface

// File: rtl/arb_timeout_counter.sv
// Stall watchdog: counts cycles a granted strobe waits without a response and
// flags expiry for one cycle when TIMEOUT_CYCLES is reached.
module arb_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_q;

  assign expired = (count_q == CW'(TIMEOUT_CYCLES));

  // Expiry self-clears so the error pulse lasts exactly one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clr || expired) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch and a load/store Wishbone master onto one
// memory port. Define ARB_ROUND_ROBIN_EN for round-robin instead of load/store priority.
module mem_port_arbiter
  import titan_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr_i,
  input  logic [31:0] i_dat_i,
  input  logic [3:0]  i_sel_i,
  input  logic        i_cyc_i,
  input  logic        i_stb_i,
  input  logic        i_we_i,
  output logic [31:0] i_dat_o,
  output logic        i_ack_o,
  output logic        i_err_o,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_dat_i,
  input  logic [3:0]  d_sel_i,
  input  logic        d_cyc_i,
  input  logic        d_stb_i,
  input  logic        d_we_i,
  output logic [31:0] d_dat_o,
  output logic        d_ack_o,
  output logic        d_err_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_dat_o,
  output logic [3:0]  m_sel_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  input  logic        m_err_i
);

  arb_state_t state_q, state_d;
  logic       grant_i, grant_d;
  logic       req_stb;
  logic       expired;
  logic       rsp_ack, rsp_err;
  logic       cnt_en, cnt_clr;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= MST_I;
    else      last_q <= last_d;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // A grant is held for the whole cycle (cyc) and always returns through IDLE.
  always_comb begin
    state_d = state_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
        if (d_cyc_i && (!i_cyc_i || last_q == MST_I)) begin
          state_d = GRANT_D;
          last_d  = MST_D;
        end else if (i_cyc_i) begin
          state_d = GRANT_I;
          last_d  = MST_I;
        end
`else
        if (d_cyc_i)      state_d = GRANT_D;
        else if (i_cyc_i) state_d = GRANT_I;
`endif
      end
      GRANT_I: if (!i_cyc_i) state_d = IDLE;
      GRANT_D: if (!d_cyc_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign grant_i = (state_q == GRANT_I);
  assign grant_d = (state_q == GRANT_D);

  always_comb begin
    m_addr_o = '0;
    m_dat_o  = '0;
    m_sel_o  = '0;
    m_we_o   = 1'b0;
    m_cyc_o  = 1'b0;
    req_stb  = 1'b0;
    if (grant_i) begin
      m_addr_o = i_addr_i;
      m_dat_o  = i_dat_i;
      m_sel_o  = i_sel_i;
      m_we_o   = i_we_i;
      m_cyc_o  = i_cyc_i;
      req_stb  = i_cyc_i & i_stb_i;
    end else if (grant_d) begin
      m_addr_o = d_addr_i;
      m_dat_o  = d_dat_i;
      m_sel_o  = d_sel_i;
      m_we_o   = d_we_i;
      m_cyc_o  = d_cyc_i;
      req_stb  = d_cyc_i & d_stb_i;
    end
  end

  // The expiry cycle withdraws the strobe and turns into a local error.
  assign m_stb_o = req_stb & ~expired;
  assign rsp_err = m_err_i | expired;
  assign rsp_ack = m_ack_i & ~m_err_i & ~expired;

  assign i_dat_o = grant_i ? m_dat_i : '0;
  assign i_ack_o = grant_i & rsp_ack;
  assign i_err_o = grant_i & rsp_err;
  assign d_dat_o = grant_d ? m_dat_i : '0;
  assign d_ack_o = grant_d & rsp_ack;
  assign d_err_o = grant_d & rsp_err;

  assign cnt_en  = req_stb & ~m_ack_i & ~m_err_i;
  assign cnt_clr = ~req_stb | m_ack_i | m_err_i;

  arb_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .en      (cnt_en),
    .clr     (cnt_clr),
    .expired (expired)
  );

endmodule
